// File: rtl/mux_scan_n.sv
// Registered N-channel scanning mux with auto dwell scanning or a manual select; optional blanking under MUX_SCAN_BLANK_EN.
// Latency: one cycle from x/sel_in/mode to o/sel_out/ch_onehot, with no combinational input-to-output path.
// Backpressure: none; en freezes the auto-scan prescaler and index, and o keeps tracking the held channel.
module mux_scan_n #(
   parameter int W    = 4,
   parameter int CH   = 8,
   parameter int DIV  = 4,
   parameter int SELW = $clog2(CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH*W-1:0]   x,
   input  logic              en,
   input  logic              mode,
   input  logic [SELW-1:0]   sel_in,
   output logic [W-1:0]      o,
   output logic [SELW-1:0]   sel_out,
   output logic [CH-1:0]     ch_onehot,
   output logic              wrap
);

   localparam int              PW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]   PLAST = PW'(DIV - 1);
   localparam logic [SELW-1:0] LAST  = SELW'(CH - 1);
   localparam logic [SELW:0]   NCH   = (SELW + 1)'(CH);

   logic [PW-1:0]   pcnt;
   logic [PW-1:0]   npcnt;
   logic [SELW-1:0] nidx;
   logic            nwrap;
   logic            blank;
   logic [W-1:0]    nxdat;
   logic [CH-1:0]   noh;

   // Next-state: sel_out doubles as the current channel index.
   always_comb begin
      npcnt = pcnt;
      nidx  = sel_out;
      nwrap = 1'b0;
      blank = 1'b0;
      if (mode) begin
         npcnt = '0;
         if ({1'b0, sel_in} < NCH) begin
            nidx = sel_in;
         end
      end else if (en) begin
         if (pcnt == PLAST) begin
            npcnt = '0;
            nidx  = (sel_out == LAST) ? '0 : sel_out + SELW'(1);
            nwrap = (sel_out == LAST);
`ifdef MUX_SCAN_BLANK_EN
            blank = (DIV > 1);
`endif
         end else begin
            npcnt = pcnt + PW'(1);
         end
      end
   end

   always_comb begin
      nxdat = '0;
      noh   = '0;
      for (int i = 0; i < CH; i++) begin
         if (nidx == SELW'(i)) begin
            nxdat  = x[i*W +: W];
            noh[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt      <= '0;
         sel_out   <= '0;
         ch_onehot <= CH'(1);
         o         <= '0;
         wrap      <= 1'b0;
      end else begin
         pcnt      <= npcnt;
         sel_out   <= nidx;
         wrap      <= nwrap;
         o         <= blank ? '0 : nxdat;
         ch_onehot <= blank ? '0 : noh;
      end
   end

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: an 8-channel and a 6-channel instance share stimulus and are checked against a tick-count model.
module tb_mux_scan_n;

   localparam int DIV = 4;

   logic        clk;
   logic        rst;
   logic        en;
   logic        mode;
   logic [2:0]  sel_in;
   logic [31:0] x;

   logic [3:0] o8;
   logic [2:0] sel8;
   logic [7:0] oh8;
   logic       wrap8;
   logic [3:0] o6;
   logic [2:0] sel6;
   logic [5:0] oh6;
   logic       wrap6;

   int n_chk;
   int n_err;

   // Model state: each auto run starts at channel base; ticks counts enabled auto cycles since then.
   int m_base  [2];
   int m_ticks [2];
   int m_cur   [2];
   int e_o     [2];
   int e_sel   [2];
   int e_oh    [2];
   int e_wrap  [2];

   mux_scan_n #(.W(4), .CH(8), .DIV(DIV)) u_dut8 (
      .clk(clk), .rst(rst), .x(x), .en(en), .mode(mode), .sel_in(sel_in),
      .o(o8), .sel_out(sel8), .ch_onehot(oh8), .wrap(wrap8)
   );

   mux_scan_n #(.W(4), .CH(6), .DIV(DIV)) u_dut6 (
      .clk(clk), .rst(rst), .x(x[23:0]), .en(en), .mode(mode), .sel_in(sel_in),
      .o(o6), .sel_out(sel6), .ch_onehot(oh6), .wrap(wrap6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic predict(input int d, input int ch);
      logic adv;
      logic bl;
      adv       = 1'b0;
      bl        = 1'b0;
      e_wrap[d] = 0;
      if (rst) begin
         m_base[d]  = 0;
         m_ticks[d] = 0;
         m_cur[d]   = 0;
         e_sel[d]   = 0;
         e_o[d]     = 0;
         e_oh[d]    = 1;
      end else begin
         if (mode) begin
            if (int'(sel_in) < ch) m_cur[d] = int'(sel_in);
            m_base[d]  = m_cur[d];
            m_ticks[d] = 0;
         end else if (en) begin
            m_ticks[d] = m_ticks[d] + 1;
            adv        = (m_ticks[d] % DIV) == 0;
            m_cur[d]   = (m_base[d] + m_ticks[d] / DIV) % ch;
            e_wrap[d]  = (adv && m_cur[d] == 0) ? 1 : 0;
         end
`ifdef MUX_SCAN_BLANK_EN
         bl = adv && (DIV > 1);
`endif
         e_sel[d] = m_cur[d];
         e_o[d]   = bl ? 0 : int'((x >> (4 * m_cur[d])) & 32'hF);
         e_oh[d]  = bl ? 0 : (1 << m_cur[d]);
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic m,
                      input logic [2:0] s, input logic [31:0] xv);
      @(negedge clk);
      rst    = r;
      en     = e;
      mode   = m;
      sel_in = s;
      x      = xv;
      predict(0, 8);
      predict(1, 6);
      @(posedge clk);
      #1;
      check("o8",    32'(o8),    e_o[0]);
      check("sel8",  32'(sel8),  e_sel[0]);
      check("oh8",   32'(oh8),   e_oh[0]);
      check("wrap8", 32'(wrap8), e_wrap[0]);
      check("o6",    32'(o6),    e_o[1]);
      check("sel6",  32'(sel6),  e_sel[1]);
      check("oh6",   32'(oh6),   e_oh[1]);
      check("wrap6", 32'(wrap6), e_wrap[1]);
   endtask

   initial begin
      logic [31:0] xv;
      logic        msticky;
      int          wraps;
      n_chk   = 0;
      n_err   = 0;
      rst     = 1'b1;
      en      = 1'b0;
      mode    = 1'b0;
      sel_in  = '0;
      x       = '0;

      // Reset with random data
      cyc(1, 1, 0, 3'($urandom), $urandom);
      cyc(1, 1, 0, 3'($urandom), $urandom);
      check("rst_oh8", 32'(oh8), 32'h01);
      check("rst_o8",  32'(o8),  32'h0);

      // Auto scan with x_i = i over more than two frames
      wraps = 0;
      for (int k = 0; k < 70; k++) begin
         cyc(0, 1, 0, 3'd0, 32'h76543210);
         if (wrap8) wraps++;
      end
      check("wrap8_count", 32'(wraps), 32'd2);

      // Freeze on channel 3, change x3 meanwhile, then resume
      cyc(1, 1, 0, 3'd0, 32'h76543210);
      for (int k = 0; k < 40 && sel8 != 3'd3; k++) cyc(0, 1, 0, 3'd0, 32'h76543210);
      check("reach_ch3", 32'(sel8), 32'd3);
      xv = 32'h76543210;
      for (int k = 0; k < 10; k++) begin
         if (k == 4) xv = 32'h7654A210;
         cyc(0, 0, 0, 3'd0, xv);
      end
      check("freeze_sel8", 32'(sel8), 32'd3);
      check("freeze_o8",   32'(o8),   32'hA);
      for (int k = 0; k < 12; k++) cyc(0, 1, 0, 3'd0, xv);

      // Manual select, including an out-of-range index for the 6-channel instance
      xv = $urandom;
      cyc(0, 1, 1, 3'd5, xv);
      cyc(0, 0, 1, 3'd5, xv);
      cyc(0, 1, 1, 3'd7, xv);
      check("man_hold_sel6", 32'(sel6), 32'd5);
      check("man_hold_oh6",  32'(oh6),  32'h20);
      cyc(0, 1, 1, 3'd7, xv);
      for (int k = 0; k < 10; k++) cyc(0, 1, 0, 3'd0, xv);

      // Randomized traffic with occasional resets and mode switches
      msticky = 1'b0;
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 19) == 0) msticky = ~msticky;
         cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0), msticky,
             3'($urandom_range(0, 7)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
